// File: rtl/spc_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spc_write_arbiter
// Purpose  : Merges write streams from four requesters into the single
//            write port of the SPC data cache. Each requester has its own
//            DEPTH-entry FIFO of {addr, data}. A round-robin arbiter pops one
//            entry per cycle into a single output register stage. Writes that
//            find a full FIFO are dropped and counted.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous active-low reset
//            req_we[3:0]  - per-requester write strobe
//            req_addr     - 4 x 32-bit addresses, requester i at [32i+31:32i]
//            req_data     - 4 x 32-bit data, packed like req_addr
//            req_en[3:0]  - per-requester enable (strobes ignored when low)
//            cache_ready  - cache accepts the current output word
//            ovf_clr      - synchronous clear of ovf and drop_cnt
//            cache_we     - output word valid
//            cache_addr   - output address
//            cache_data   - output data
//            cache_src    - requester index owning the output word
//            ovf[3:0]     - sticky per-requester overflow flags
//            drop_cnt     - saturating count of dropped writes
//            busy         - any FIFO non-empty or output word valid
// Options  : SPC_ARB_SRCTAG_EN - when defined, cache_addr[31:30] carries the
//            granted requester index instead of the queued address bits.
// Revision : 1.0 - initial release
// ============================================================================
module spc_write_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_we,
  input  logic [127:0] req_addr,
  input  logic [127:0] req_data,
  input  logic [3:0]   req_en,
  input  logic         cache_ready,
  input  logic         ovf_clr,
  output logic         cache_we,
  output logic [31:0]  cache_addr,
  output logic [31:0]  cache_data,
  output logic [1:0]   cache_src,
  output logic [3:0]   ovf,
  output logic [7:0]   drop_cnt,
  output logic         busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]  empty;
  logic [3:0]  full;
  logic [3:0]  wants;
  logic [3:0]  push;
  logic [3:0]  pop;
  logic [3:0]  drop;
  logic [31:0] head_addr [4];
  logic [31:0] head_data [4];
  logic [1:0]  last_grant;
  logic [1:0]  grant;
  logic [1:0]  rr_idx;
  logic        grant_vld;
  logic        loadable;
  logic [2:0]  ndrops;
  logic [8:0]  drop_sum;
  logic [31:0] load_addr;

  // --------------------------------------------------------------------------
  // Per-requester FIFOs
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < 4; g++) begin : g_fifo
      logic [63:0]   mem [DEPTH];
      logic [AW-1:0] wr_ptr;
      logic [AW-1:0] rd_ptr;
      logic [AW:0]   count;

      assign empty[g] = (count == '0);
      assign full[g]  = (count == (AW+1)'(DEPTH));

      // Storage carries no reset; validity is tracked by count alone.
      always_ff @(posedge clk) begin
        if (push[g]) begin
          mem[wr_ptr] <= {req_addr[32*g +: 32], req_data[32*g +: 32]};
        end
      end

      // Pointers wrap naturally because DEPTH is a power of two.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push[g]) wr_ptr <= wr_ptr + 1'b1;
          if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
          case ({push[g], pop[g]})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
          endcase
        end
      end

      assign head_addr[g] = mem[rd_ptr][63:32];
      assign head_data[g] = mem[rd_ptr][31:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin grant: search starts one past the last winner.
  // --------------------------------------------------------------------------
  always_comb begin
    grant     = 2'd0;
    grant_vld = 1'b0;
    rr_idx    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      rr_idx = last_grant + 2'(k);
      if (!grant_vld && !empty[rr_idx]) begin
        grant     = rr_idx;
        grant_vld = 1'b1;
      end
    end
  end

  assign loadable = !cache_we || cache_ready;

  // A full FIFO still accepts a push when it is being popped in the same cycle.
  always_comb begin
    wants = req_we & req_en;
    pop   = 4'b0000;
    if (loadable && grant_vld) pop[grant] = 1'b1;
    push  = wants & (~full | pop);
    drop  = wants & full & ~pop;
  end

  assign ndrops   = {2'b00, drop[0]} + {2'b00, drop[1]} +
                    {2'b00, drop[2]} + {2'b00, drop[3]};
  assign drop_sum = {1'b0, drop_cnt} + {6'b000000, ndrops};

`ifdef SPC_ARB_SRCTAG_EN
  assign load_addr = {grant, head_addr[grant][29:0]};
`else
  assign load_addr = head_addr[grant];
`endif

  // --------------------------------------------------------------------------
  // Output register stage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_we   <= 1'b0;
      cache_addr <= '0;
      cache_data <= '0;
      cache_src  <= '0;
      last_grant <= 2'd3;
    end else if (loadable) begin
      if (grant_vld) begin
        cache_we   <= 1'b1;
        cache_addr <= load_addr;
        cache_data <= head_data[grant];
        cache_src  <= grant;
        last_grant <= grant;
      end else begin
        cache_we   <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Overflow tracking: a drop in the same cycle as ovf_clr survives the clear.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf      <= '0;
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      ovf      <= drop;
      drop_cnt <= {5'b00000, ndrops};
    end else begin
      ovf      <= ovf | drop;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign busy = cache_we || !(&empty);

endmodule
`default_nettype wire
